dll_dcntl_tracker: RTL and testbench

- Downstream consumer of the ECP3 master DLL's 6-bit delay control code (DCNTL5..0) and LOCK.
- Periodically pulses the DLL's UDDCNTL update input, waits for the code to settle, and double-samples it to reject glitches.
- Applies a signed user offset with saturation, then drives a registered slave delay code with a valid flag to DQS/IO delay cells.
- Sits between the DLL macro and the slave delay lines, in the same clock domain as CLKI.

---
 rtl/dll_trk_pkg.sv | 21 ++
 rtl/dll_code_sat_add.sv | 31 +++
 rtl/dll_dcntl_tracker.sv | 194 +++++++++++++++++++
 tb/tb_dll_dcntl_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_trk_pkg.sv
// Shared state type and code-width constants for the DLL delay-code tracker.
package dll_trk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOCKWAIT = 3'd1,
        ST_REQ      = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_SAMP1    = 3'd4,
        ST_SAMP2    = 3'd5,
        ST_HOLD     = 3'd6
    } trk_state_e;

    localparam int CODE_W   = 6;
    localparam int CODE_MAX = 63;
    localparam int CODE_MIN = 0;
    localparam int OFS_W    = 7;
    // Wide enough for 0..63 plus -64..+63 without wrapping.
    localparam int SUM_W    = 8;

endpackage

// File: rtl/dll_code_sat_add.sv
// Combinational 6-bit unsigned code plus 7-bit signed offset, clamped to the
// legal delay-code range.
module dll_code_sat_add
    import dll_trk_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic [OFS_W-1:0]  ofs_i,
    output logic [CODE_W-1:0] sum_o
);

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(CODE_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(CODE_MIN);

    logic signed [SUM_W-1:0] code_ext;
    logic signed [SUM_W-1:0] ofs_ext;
    logic signed [SUM_W-1:0] sum_ext;

    always_comb begin
        code_ext = {{(SUM_W-CODE_W){1'b0}}, code_i};
        ofs_ext  = {{(SUM_W-OFS_W){ofs_i[OFS_W-1]}}, ofs_i};
        sum_ext  = code_ext + ofs_ext;
        if (sum_ext < SUM_MIN) begin
            sum_o = CODE_W'(CODE_MIN);
        end else if (sum_ext > SUM_MAX) begin
            sum_o = CODE_W'(CODE_MAX);
        end else begin
            sum_o = sum_ext[CODE_W-1:0];
        end
    end

endmodule

// File: rtl/dll_dcntl_tracker.sv
// Tracks the DLL delay code: periodic UDDCNTL updates, double-sampling, offset
// with saturation. Optional hysteresis on the slave code via `DCNTL_HYST_EN.
module dll_dcntl_tracker
    import dll_trk_pkg::*;
#(
    parameter int LOCK_WAIT    = 64,
    parameter int UPD_PULSE    = 2,
    parameter int SETTLE       = 4,
    parameter int UPD_INTERVAL = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int HYST         = 1
) (
    input  logic              CLKI,
    input  logic              RSTN,
    input  logic              DLL_LOCK,
    input  logic [CODE_W-1:0] DCNTL,
    input  logic [OFS_W-1:0]  OFFSET,
    input  logic              FREEZE,
    output logic              UDDCNTL,
    output logic [CODE_W-1:0] SDCNTL,
    output logic              SVALID,
    output logic              ERR
);

    localparam int CNT_A   = (LOCK_WAIT > UPD_INTERVAL) ? LOCK_WAIT : UPD_INTERVAL;
    localparam int CNT_B   = (UPD_PULSE > SETTLE) ? UPD_PULSE : SETTLE;
    localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] LW_TC    = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(UPD_PULSE - 1);
    localparam logic [CNT_W-1:0] SET_TC   = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] INT_TC   = CNT_W'(UPD_INTERVAL - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    if (LOCK_WAIT < 1 || UPD_PULSE < 1 || SETTLE < 1 || UPD_INTERVAL < 1 ||
        MAX_RETRY < 1 || HYST < 0 || HYST > CODE_MAX) begin : g_bad_params
        $error("dll_dcntl_tracker: illegal parameter value");
    end

    trk_state_e        state_q, state_d;
    logic              lock_meta_q, lock_meta_d;
    logic              lock_s_q, lock_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [CODE_W-1:0] s1_q, s1_d;
    logic [CODE_W-1:0] sdcntl_q, sdcntl_d;
    logic              svalid_q, svalid_d;
    logic              err_q, err_d;

    logic [CODE_W-1:0] sat_code;
    logic              load_en;

    dll_code_sat_add u_sat_add (
        .code_i (s1_q),
        .ofs_i  (OFFSET),
        .sum_o  (sat_code)
    );

`ifdef DCNTL_HYST_EN
    localparam logic [CODE_W-1:0] HYST_T = CODE_W'(HYST);
    logic [CODE_W-1:0] code_diff;

    // Small steps are suppressed only once a valid code is already driven.
    always_comb begin
        code_diff = (sat_code > sdcntl_q) ? (sat_code - sdcntl_q) : (sdcntl_q - sat_code);
        load_en   = !svalid_q || (code_diff > HYST_T);
    end
`else
    always_comb begin
        load_en = 1'b1;
    end
`endif

    always_comb begin
        lock_meta_d = DLL_LOCK;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        s1_d        = s1_q;
        sdcntl_d    = sdcntl_q;
        svalid_d    = svalid_q;
        err_d       = err_q;

        // Lock loss overrides everything, including a matching SAMP2.
        if (!lock_s_q) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            retry_d  = '0;
            svalid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOCKWAIT;
                    cnt_d   = '0;
                end
                ST_LOCKWAIT: begin
                    if (cnt_q == LW_TC) begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (cnt_q == PULSE_TC) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SET_TC) begin
                        state_d = ST_SAMP1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SAMP1: begin
                    s1_d    = DCNTL;
                    state_d = ST_SAMP2;
                end
                ST_SAMP2: begin
                    cnt_d = '0;
                    if (DCNTL == s1_q) begin
                        retry_d  = '0;
                        svalid_d = 1'b1;
                        state_d  = ST_HOLD;
                        if (load_en) begin
                            sdcntl_d = sat_code;
                        end
                    end else begin
                        if (retry_q != RTY_MAX) begin
                            retry_d = retry_q + 1'b1;
                        end
                        if (retry_d == RTY_MAX) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    // FREEZE parks the counter at terminal until it drops.
                    if (cnt_q == INT_TC) begin
                        if (!FREEZE) begin
                            state_d = ST_REQ;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_q       <= '0;
            retry_q     <= '0;
            s1_q        <= '0;
            sdcntl_q    <= '0;
            svalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            s1_q        <= s1_d;
            sdcntl_q    <= sdcntl_d;
            svalid_q    <= svalid_d;
            err_q       <= err_d;
        end
    end

    assign UDDCNTL = lock_s_q && (state_q == ST_REQ);
    assign SDCNTL  = sdcntl_q;
    assign SVALID  = svalid_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_dll_dcntl_tracker.sv
// Self-checking bench for dll_dcntl_tracker: vector table plus scoreboard, with
// hand sequences for lock-up, glitch retry, lock loss and FREEZE.
module tb_dll_dcntl_tracker;

    localparam int LW         = 8;
    localparam int PULSE      = 2;
    localparam int SET        = 4;
    localparam int INTV       = 16;
    localparam int RTY        = 3;
    localparam int HYS        = 1;
    localparam int REQ_TO_OUT = PULSE + SET + 2;
    localparam int NV         = 6;

    logic       CLKI = 1'b0;
    logic       RSTN;
    logic       DLL_LOCK;
    logic [5:0] DCNTL;
    logic [6:0] OFFSET;
    logic       FREEZE;
    logic       UDDCNTL;
    logic [5:0] SDCNTL;
    logic       SVALID;
    logic       ERR;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic [5:0] sd;
        logic       sv;
        logic       er;
    } exp_t;

    typedef struct {
        logic [5:0] dc;
        int         ofs;
        int         sd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[NV];

    always #5 CLKI = ~CLKI;

    dll_dcntl_tracker #(
        .LOCK_WAIT    (LW),
        .UPD_PULSE    (PULSE),
        .SETTLE       (SET),
        .UPD_INTERVAL (INTV),
        .MAX_RETRY    (RTY),
        .HYST         (HYS)
    ) dut (
        .CLKI     (CLKI),
        .RSTN     (RSTN),
        .DLL_LOCK (DLL_LOCK),
        .DCNTL    (DCNTL),
        .OFFSET   (OFFSET),
        .FREEZE   (FREEZE),
        .UDDCNTL  (UDDCNTL),
        .SDCNTL   (SDCNTL),
        .SVALID   (SVALID),
        .ERR      (ERR)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLKI);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_stimulus(input logic [5:0] dc, input logic [6:0] ofs, input string name,
                                  input int exp_sd, input logic exp_sv, input logic exp_er);
        DCNTL  = dc;
        OFFSET = ofs;
        sb.push_back('{name: name, sd: 6'(exp_sd), sv: exp_sv, er: exp_er});
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        check({e.name, "_sdcntl"}, 32'(SDCNTL), 32'(e.sd));
        check({e.name, "_svalid"}, 32'(SVALID), 32'(e.sv));
        check({e.name, "_err"},    32'(ERR),    32'(e.er));
    endtask

    task automatic wait_req(input string name, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (UDDCNTL === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            $display("[TB] FAIL %s_wait: got no UDDCNTL in %0d cycles, expected a request", name, budget);
            if (sb.size() > 0) sb.delete(0);
        end
    endtask

    // Waits for the next request, then checks pulse width, the unchanged code
    // one cycle before the update, and the scoreboard entry when it lands.
    task automatic do_update(input string name, input int prev_sd);
        bit ok;
        wait_req(name, 4 * INTV, ok);
        if (ok) begin
            tick(PULSE);
            check({name, "_pulse_end"}, 32'(UDDCNTL), 0);
            tick(REQ_TO_OUT - 1 - PULSE);
            check({name, "_pre"}, 32'(SDCNTL), 32'(prev_sd));
            tick();
            check_output();
        end
    endtask

    task automatic lock_sequence(input string name, input logic [5:0] dc, input int exp_sd, input logic exp_er);
        DCNTL    = dc;
        DLL_LOCK = 1'b1;
        sb.push_back('{name: name, sd: 6'(exp_sd), sv: 1'b1, er: exp_er});
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 10 || c == 13) check($sformatf("%s_upd_c%0d", name, c), 32'(UDDCNTL), 0);
            else if (c == 11 || c == 12) check($sformatf("%s_upd_c%0d", name, c), 32'(UDDCNTL), 1);
            else if (c == 18) check($sformatf("%s_sv_c%0d", name, c), 32'(SVALID), 0);
            else if (c == 19) check_output();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time %0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int cur_sd;
        int n_req;
        logic [5:0] exp21;

        vecs[0] = '{dc: 6'd60, ofs:  10, sd: 63};
        vecs[1] = '{dc: 6'd5,  ofs:  -8, sd: 0};
        vecs[2] = '{dc: 6'd30, ofs: -64, sd: 0};
        vecs[3] = '{dc: 6'd40, ofs:  -5, sd: 35};
        vecs[4] = '{dc: 6'd0,  ofs:  63, sd: 63};
        vecs[5] = '{dc: 6'd63, ofs:  -3, sd: 60};

        RSTN     = 1'b0;
        DLL_LOCK = 1'b0;
        FREEZE   = 1'b0;
        DCNTL    = 6'd20;
        OFFSET   = 7'd0;
        tick(3);
        check("rst_uddcntl", 32'(UDDCNTL), 0);
        check("rst_sdcntl",  32'(SDCNTL),  0);
        check("rst_svalid",  32'(SVALID),  0);
        check("rst_err",     32'(ERR),     0);
        RSTN = 1'b1;
        tick(2);

        lock_sequence("first_lock", 6'd20, 20, 1'b0);
        cur_sd = 20;

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i].dc, 7'(vecs[i].ofs), $sformatf("vec%0d", i), vecs[i].sd, 1'b1, 1'b0);
            tick();
            check($sformatf("vec%0d_hold", i), 32'(SDCNTL), 32'(cur_sd));
            do_update($sformatf("vec%0d", i), cur_sd);
            cur_sd = vecs[i].sd;
        end

`ifdef DCNTL_HYST_EN
        exp21 = 6'd20;
`else
        exp21 = 6'd21;
`endif
        apply_stimulus(6'd20, 7'd0, "hyst_a", 20, 1'b1, 1'b0);
        do_update("hyst_a", cur_sd);
        apply_stimulus(6'd21, 7'd0, "hyst_b", 32'(exp21), 1'b1, 1'b0);
        do_update("hyst_b", 20);
        apply_stimulus(6'd23, 7'd0, "hyst_c", 23, 1'b1, 1'b0);
        do_update("hyst_c", 32'(exp21));

        FREEZE = 1'b1;
        n_req  = 0;
        for (int c = 0; c < 2 * INTV + 8; c++) begin
            tick();
            if (UDDCNTL === 1'b1) n_req++;
        end
        check("freeze_no_req", 32'(n_req), 0);
        check("freeze_svalid", 32'(SVALID), 1);
        sb.push_back('{name: "freeze_rel", sd: 6'd23, sv: 1'b1, er: 1'b0});
        FREEZE = 1'b0;
        tick();
        check("freeze_rel_c1", 32'(UDDCNTL), 1);
        tick();
        check("freeze_rel_c2", 32'(UDDCNTL), 1);
        tick();
        check("freeze_rel_c3", 32'(UDDCNTL), 0);
        tick(REQ_TO_OUT - 2);
        check_output();

        apply_stimulus(6'd25, 7'd0, "freeze_in_req", 25, 1'b1, 1'b0);
        wait_req("freeze_in_req", 4 * INTV, ok);
        if (ok) begin
            FREEZE = 1'b1;
            tick(REQ_TO_OUT);
            check_output();
            FREEZE = 1'b0;
        end

        DCNTL = 6'd20;
        wait_req("glitch", 4 * INTV, ok);
        if (ok) begin
            for (int k = 0; k < RTY; k++) begin
                tick(REQ_TO_OUT - 2);
                DCNTL = 6'd20;
                tick();
                DCNTL = 6'd21;
                tick();
                check($sformatf("glitch%0d_retry_req", k), 32'(UDDCNTL), 1);
                check($sformatf("glitch%0d_sdcntl", k), 32'(SDCNTL), 25);
                check($sformatf("glitch%0d_err", k), 32'(ERR), (k == RTY - 1) ? 1 : 0);
            end
            apply_stimulus(6'd22, 7'd0, "glitch_settle", 22, 1'b1, 1'b1);
            tick(REQ_TO_OUT);
            check_output();
        end

        DLL_LOCK = 1'b0;
        n_req    = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (UDDCNTL === 1'b1) n_req++;
            if (c == 3) check("lockloss_svalid_c3", 32'(SVALID), 0);
        end
        check("lockloss_no_req", 32'(n_req), 0);
        check("lockloss_sdcntl", 32'(SDCNTL), 22);
        check("lockloss_err", 32'(ERR), 1);

        lock_sequence("relock", 6'd23, 23, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
